// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light sequencer and its downstream supervisor:
// light codes, fault codes, the pedestrian FSM state type and small code helpers.
package traffic_pkg;

  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] AMBER = 3'b010;
  localparam logic [2:0] GREEN = 3'b001;

  localparam logic [1:0] FLT_NONE  = 2'b00;
  localparam logic [1:0] FLT_CODE  = 2'b01;
  localparam logic [1:0] FLT_SEQ   = 2'b10;
  localparam logic [1:0] FLT_STUCK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WALK,
    ST_CLEAR,
    ST_FAULT
  } walk_state_t;

  // True only for the three defined lamp codes.
  function automatic logic is_onehot(input logic [2:0] code);
    return (code == RED) || (code == AMBER) || (code == GREEN);
  endfunction

  // The single code the sequencer may move to from the given code.
  function automatic logic [2:0] legal_succ(input logic [2:0] code);
    logic [2:0] nxt;
    case (code)
      AMBER:   nxt = GREEN;
      GREEN:   nxt = RED;
      RED:     nxt = AMBER;
      default: nxt = 3'b000;
    endcase
    return nxt;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/light_checker.sv
// Light-code checker: keeps the previous sample and a repeat counter and flags
// illegal codes, illegal transitions and stuck phases for the current sample.
module light_checker
  import traffic_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [2:0] light,
  output logic       fault_det,
  output logic [1:0] code_det
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD - 1);

  logic [2:0]       light_q;
  logic             valid;
  logic [CNT_W-1:0] hold_cnt;

  // Previous sample; only meaningful while valid is set, so it carries no reset.
  always_ff @(posedge clk) begin
    light_q <= light;
  end

  // Sample-valid flag and repeat counter; a clear makes the next sample the first one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      hold_cnt <= '0;
    end else if (clr) begin
      valid    <= 1'b0;
      hold_cnt <= '0;
    end else begin
      valid <= 1'b1;
      if (valid && (light == light_q)) begin
        if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + CNT_W'(1);
      end else begin
        hold_cnt <= '0;
      end
    end
  end

  // Fault classification for the sample at the coming edge, highest priority first.
  always_comb begin
    fault_det = 1'b0;
    code_det  = FLT_NONE;
    if (!is_onehot(light)) begin
      fault_det = 1'b1;
      code_det  = FLT_CODE;
    end else if (valid && (light != light_q) && (light != legal_succ(light_q))) begin
      fault_det = 1'b1;
      code_det  = FLT_SEQ;
    end else if (valid && (light == light_q) && (hold_cnt == HOLD_MAX)) begin
      fault_det = 1'b1;
      code_det  = FLT_STUCK;
    end
  end

endmodule

// File: rtl/light_supervisor.sv
// Supervisor for the traffic-light sequencer: pedestrian walk/clearance FSM slaved to
// the red phase plus a sticky fault register that forces flashing don't-walk.
module light_supervisor
  import traffic_pkg::*;
#(
  parameter int WALK_CYC  = 4,
  parameter int CLEAR_CYC = 2,
  parameter int MAX_HOLD  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] light,
  input  logic       ped_req,
  input  logic       fault_clr,
  output logic       walk,
  output logic       dont_walk,
  output logic       flash,
  output logic       ped_ack,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int CNT_W = $clog2(max3(WALK_CYC, CLEAR_CYC, MAX_HOLD) + 1);

  walk_state_t      state;
  logic             pending;
  logic [CNT_W-1:0] cnt;
  logic             fault_det;
  logic [1:0]       code_det;
  logic             chk_clr;

  // Only a clear that actually leaves FAULT restarts the checker history.
  assign chk_clr = fault_clr && (state == ST_FAULT);

  light_checker #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (chk_clr),
    .light     (light),
    .fault_det (fault_det),
    .code_det  (code_det)
  );

  // Walk FSM with registered lamp outputs; a new fault overrides any state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pending    <= 1'b0;
      cnt        <= '0;
      walk       <= 1'b0;
      dont_walk  <= 1'b1;
      flash      <= 1'b0;
      ped_ack    <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FLT_NONE;
    end else begin
      ped_ack <= 1'b0;
      if ((state != ST_FAULT) && fault_det) begin
        state      <= ST_FAULT;
        fault      <= 1'b1;
        fault_code <= code_det;
        walk       <= 1'b0;
        dont_walk  <= 1'b1;
        flash      <= 1'b1;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if ((pending || ped_req) && (light == RED)) begin
              state     <= ST_WALK;
              pending   <= 1'b0;
              ped_ack   <= 1'b1;
              walk      <= 1'b1;
              dont_walk <= 1'b0;
              flash     <= 1'b0;
              cnt       <= CNT_W'(WALK_CYC - 1);
            end else begin
              pending <= pending | ped_req;
            end
          end
          ST_WALK: begin
            if ((cnt == '0) || (light != RED)) begin
              state     <= ST_CLEAR;
              walk      <= 1'b0;
              dont_walk <= 1'b1;
              flash     <= 1'b1;
              cnt       <= CNT_W'(CLEAR_CYC - 1);
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_CLEAR: begin
            pending <= pending | ped_req;
            if (cnt == '0) begin
              state <= ST_IDLE;
              flash <= 1'b0;
            end else begin
              cnt   <= cnt - CNT_W'(1);
              flash <= ~flash;
            end
          end
          ST_FAULT: begin
            if (fault_clr) begin
              state      <= ST_IDLE;
              fault      <= 1'b0;
              fault_code <= FLT_NONE;
              pending    <= 1'b0;
              walk       <= 1'b0;
              dont_walk  <= 1'b1;
              flash      <= 1'b0;
            end else begin
              flash <= ~flash;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_light_supervisor.sv
// Directed bench for light_supervisor with hand-computed expected lamp/fault values.
module tb_light_supervisor;
  import traffic_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [2:0] light;
  logic       ped_req;
  logic       fault_clr;
  logic       walk;
  logic       dont_walk;
  logic       flash;
  logic       ped_ack;
  logic       fault;
  logic [1:0] fault_code;

  int checks = 0;
  int errors = 0;

  light_supervisor #(
    .WALK_CYC  (4),
    .CLEAR_CYC (2),
    .MAX_HOLD  (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .light      (light),
    .ped_req    (ped_req),
    .fault_clr  (fault_clr),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .flash      (flash),
    .ped_ack    (ped_ack),
    .fault      (fault),
    .fault_code (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one sample on the falling edge, then settle just after the rising edge.
  task automatic step(input logic [2:0] l, input logic req, input logic clr);
    @(negedge clk);
    light     = l;
    ped_req   = req;
    fault_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    light     = RED;
    ped_req   = 1'b0;
    fault_clr = 1'b0;
    #12;
    chk("reset_lamps", {walk, dont_walk, flash, ped_ack}, 4'b0100);
    chk("reset_fault", {fault, fault_code}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal cycling, no requests: lamps idle, no faults.
    for (int i = 0; i < 30; i++) begin
      step((i % 3 == 0) ? AMBER : (i % 3 == 1) ? GREEN : RED, 1'b0, 1'b0);
      chk($sformatf("cycle_%0d", i), {fault, dont_walk, walk}, 3'b010);
    end

    // Request during GREEN, walk cut short by AMBER, then clearance flash 1,0.
    step(AMBER, 1'b0, 1'b0);
    step(GREEN, 1'b1, 1'b0);
    chk("req_green", {walk, ped_ack}, 2'b00);
    step(RED, 1'b0, 1'b0);
    chk("walk_entry", {walk, dont_walk, ped_ack}, 3'b101);
    step(AMBER, 1'b0, 1'b0);
    chk("clear1", {walk, dont_walk, flash, ped_ack}, 4'b0110);
    step(GREEN, 1'b0, 1'b0);
    chk("clear2", {walk, dont_walk, flash}, 3'b010);
    step(RED, 1'b0, 1'b0);
    chk("back_idle", {walk, dont_walk, flash, ped_ack, fault}, 5'b01000);

    // Pending request, RED held: walk exactly WALK_CYC cycles, no stuck fault.
    step(AMBER, 1'b0, 1'b0);
    step(GREEN, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(RED, 1'b0, 1'b0);
      chk($sformatf("walk_%0d", i), {walk, ped_ack, fault}, {1'b1, (i == 0), 1'b0});
    end
    step(RED, 1'b0, 1'b0);
    chk("walk_expire", {walk, dont_walk, flash, fault}, 4'b0110);
    step(AMBER, 1'b0, 1'b0);
    chk("walk_exp_clr2", {walk, flash}, 2'b00);
    step(GREEN, 1'b0, 1'b0);
    chk("walk_exp_idle", {walk, dont_walk, fault}, 3'b010);

    // Illegal code: fault on the sampling edge, flashing don't-walk.
    step(3'b011, 1'b0, 1'b0);
    chk("code_fault", {fault, fault_code}, {1'b1, FLT_CODE});
    chk("code_lamps", {walk, dont_walk, flash}, 3'b011);
    step(GREEN, 1'b0, 1'b0);
    chk("fault_flash0", {fault, flash}, 2'b10);
    step(GREEN, 1'b0, 1'b0);
    chk("fault_flash1", {fault, flash}, 2'b11);
    // Clear wins over a simultaneous new violation.
    step(3'b111, 1'b0, 1'b1);
    chk("clr_wins", {fault, fault_code, flash, dont_walk}, 5'b00001);
    // History was cleared: 111 -> RED is a first sample, not a transition.
    step(RED, 1'b0, 1'b0);
    chk("first_after_clr", {fault, fault_code}, 3'b000);

    // Illegal transition AMBER -> RED, coinciding with a walk request: fault wins.
    step(AMBER, 1'b0, 1'b0);
    chk("amber_ok", fault, 1'b0);
    step(RED, 1'b1, 1'b0);
    chk("seq_fault", {fault, fault_code}, {1'b1, FLT_SEQ});
    chk("seq_no_walk", {walk, ped_ack}, 2'b00);
    step(GREEN, 1'b0, 1'b1);
    chk("seq_clr", {fault, fault_code}, 3'b000);

    // Stuck GREEN: fault on the 9th identical sample.
    for (int i = 1; i <= 9; i++) begin
      step(GREEN, 1'b0, 1'b0);
      chk($sformatf("hold_%0d", i), fault, (i == 9));
    end
    chk("stuck_code", fault_code, FLT_STUCK);
    // fault_clr outside FAULT is inert; first clear it properly.
    step(AMBER, 1'b0, 1'b1);
    chk("stuck_clr", {fault, fault_code}, 3'b000);

    // Asynchronous reset in the middle of WALK.
    step(GREEN, 1'b1, 1'b0);
    step(RED, 1'b0, 1'b0);
    chk("pre_rst_walk", {walk, ped_ack}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_walk", {walk, dont_walk, flash, ped_ack, fault, fault_code}, 7'b0100000);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of FAULT.
    step(3'b000, 1'b0, 1'b0);
    chk("pre_rst_fault", {fault, fault_code}, {1'b1, FLT_CODE});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_fault", {walk, dont_walk, flash, ped_ack, fault, fault_code}, 7'b0100000);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
